// File: rtl/drcp_pkg.sv
// rtl/drcp_pkg.sv - shared types and constants for the fgpio command sequencer
package drcp_pkg;

    localparam int FGPIO_SEQ_DEPTH = 8;

    typedef enum logic [1:0] {
        FGPIO_RD_ALL = 2'd0,
        FGPIO_RD_BIT = 2'd1,
        FGPIO_WR     = 2'd2,
        FGPIO_WR_AND = 2'd3
    } fgpio_op_e;

    typedef struct packed {
        fgpio_op_e   op;
        logic [15:0] delay;
        logic [31:0] arg0;
        logic [31:0] arg1;
    } fgpio_seq_cmd_t;

    localparam logic [6:0] FGPIO_F7_RD_ALL = 7'b0000000;
    localparam logic [6:0] FGPIO_F7_RD_BIT = 7'b0000001;
    localparam logic [6:0] FGPIO_F7_WR     = 7'b1000000;
    localparam logic [6:0] FGPIO_F7_WR_AND = 7'b1000001;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_WAIT = 2'd2
    } fgpio_seq_state_e;

    function automatic logic [6:0] fgpio_op_to_f7(input fgpio_op_e op);
        case (op)
            FGPIO_RD_ALL: return FGPIO_F7_RD_ALL;
            FGPIO_RD_BIT: return FGPIO_F7_RD_BIT;
            FGPIO_WR:     return FGPIO_F7_WR;
            default:      return FGPIO_F7_WR_AND;
        endcase
    endfunction

    function automatic logic fgpio_op_is_read(input fgpio_op_e op);
        return (op == FGPIO_RD_ALL) || (op == FGPIO_RD_BIT);
    endfunction

endpackage

// File: rtl/fgpio_seq_fifo.sv
// rtl/fgpio_seq_fifo.sv - show-ahead command queue with flush
module fgpio_seq_fifo
    import drcp_pkg::*;
#(
    parameter int DEPTH = FGPIO_SEQ_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  fgpio_seq_cmd_t           data_i,
    output fgpio_seq_cmd_t           data_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fgpio_seq_cmd_t r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_cnt;
    logic           w_push;
    logic           w_pop;

    // Flush beats push and pop; a full queue drops the push silently.
    assign w_push = push_i && (r_cnt != FULL_CNT) && !flush_i;
    assign w_pop  = pop_i && (r_cnt != '0) && !flush_i;

    assign full_o = (r_cnt == FULL_CNT);
    assign cnt_o  = r_cnt;
    assign data_o = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fgpio_seq.sv
// rtl/fgpio_seq.sv - timed fgpio command sequencer sharing the bus with the core
module fgpio_seq
    import drcp_pkg::*;
#(
    parameter int DEPTH = FGPIO_SEQ_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [15:0]            cmd_delay_i,
    input  logic [31:0]            cmd_arg0_i,
    input  logic [31:0]            cmd_arg1_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   err_clr_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] cmd_cnt_o,
    input  logic                   core_req_i,
    input  logic [6:0]             core_funct7_i,
    input  logic [31:0]            core_rs1_i,
    input  logic [31:0]            core_rs2_i,
    output logic                   core_ack_o,
    output logic                   core_error_o,
    output logic [31:0]            core_rd_o,
    output logic                   fgpio_req_o,
    output logic [6:0]             fgpio_funct7_o,
    output logic [31:0]            fgpio_rs1_val_o,
    output logic [31:0]            fgpio_rs2_val_o,
    input  logic                   fgpio_ack_i,
    input  logic                   fgpio_error_i,
    input  logic [31:0]            fgpio_rd_val_i,
    output logic                   smp_valid_o,
    output logic [31:0]            smp_data_o
);

    fgpio_seq_state_e        r_state;
    fgpio_seq_state_e        w_next_state;
    logic [15:0]             r_delay_cnt;
    logic                    r_err;
    logic                    r_smp_valid;
    logic [31:0]             r_smp_data;
    fgpio_seq_cmd_t          w_in_cmd;
    fgpio_seq_cmd_t          w_head;
    logic [$clog2(DEPTH):0]  w_cnt;
    logic                    w_full;
    logic                    w_push;
    logic                    w_nonempty;
    logic                    w_issue;
    logic [15:0]             w_load_delay;

    assign w_in_cmd = '{op: fgpio_op_e'(cmd_op_i), delay: cmd_delay_i,
                        arg0: cmd_arg0_i, arg1: cmd_arg1_i};
    assign w_push   = cmd_valid_i && !w_full;

    // A push landing in the LOAD cycle still counts; its delay is taken from the inputs.
    assign w_nonempty   = (w_cnt != '0) || w_push;
    assign w_load_delay = (w_cnt != '0) ? w_head.delay : cmd_delay_i;
    assign w_issue      = (r_state == SEQ_WAIT) && (r_delay_cnt == 16'd0) && !abort_i;

    fgpio_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (abort_i),
        .push_i  (w_push),
        .pop_i   (w_issue),
        .data_i  (w_in_cmd),
        .data_o  (w_head),
        .cnt_o   (w_cnt),
        .full_o  (w_full)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= SEQ_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (abort_i) begin
            w_next_state = SEQ_IDLE;
        end else begin
            case (r_state)
                SEQ_IDLE: if (start_i && (w_cnt != '0)) w_next_state = SEQ_LOAD;
                SEQ_LOAD: w_next_state = w_nonempty ? SEQ_WAIT : SEQ_IDLE;
                SEQ_WAIT: if (r_delay_cnt == 16'd0) w_next_state = SEQ_LOAD;
                default:  w_next_state = SEQ_IDLE;
            endcase
        end
    end

    // Delay counter: loaded in LOAD, counts down in WAIT, saturates at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_delay_cnt <= 16'd0;
        end else if (abort_i) begin
            r_delay_cnt <= 16'd0;
        end else if (r_state == SEQ_LOAD && w_nonempty) begin
            r_delay_cnt <= w_load_delay;
        end else if (r_state == SEQ_WAIT && r_delay_cnt != 16'd0) begin
            r_delay_cnt <= r_delay_cnt - 16'd1;
        end
    end

    // Sticky error and read-sample capture; a set in the clear cycle wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err       <= 1'b0;
            r_smp_valid <= 1'b0;
            r_smp_data  <= 32'd0;
        end else begin
            if (w_issue && fgpio_error_i) r_err <= 1'b1;
            else if (err_clr_i)           r_err <= 1'b0;
            r_smp_valid <= w_issue && fgpio_op_is_read(w_head.op);
            if (w_issue && fgpio_op_is_read(w_head.op)) r_smp_data <= fgpio_rd_val_i;
        end
    end

    // Output decode: the sequencer owns the bus in the issue cycle, else pass-through.
    always_comb begin
        busy_o          = (r_state != SEQ_IDLE);
        done_o          = (r_state == SEQ_LOAD) && !w_nonempty && !abort_i;
        fgpio_req_o     = core_req_i;
        fgpio_funct7_o  = core_funct7_i;
        fgpio_rs1_val_o = core_rs1_i;
        fgpio_rs2_val_o = core_rs2_i;
        core_ack_o      = fgpio_ack_i;
        core_error_o    = fgpio_error_i;
        core_rd_o       = fgpio_rd_val_i;
        if (w_issue) begin
            fgpio_req_o     = 1'b1;
            fgpio_funct7_o  = fgpio_op_to_f7(w_head.op);
            fgpio_rs1_val_o = w_head.arg0;
            fgpio_rs2_val_o = w_head.arg1;
            core_ack_o      = 1'b0;
            core_error_o    = 1'b0;
            core_rd_o       = 32'd0;
        end
    end

    assign cmd_ready_o = !w_full;
    assign cmd_cnt_o   = w_cnt;
    assign err_o       = r_err;
    assign smp_valid_o = r_smp_valid;
    assign smp_data_o  = r_smp_data;

endmodule

// File: tb/tb_fgpio_seq.sv
// tb/tb_fgpio_seq.sv - directed self-checking bench for fgpio_seq
module tb_fgpio_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [15:0] cmd_delay_i;
    logic [31:0] cmd_arg0_i;
    logic [31:0] cmd_arg1_i;
    logic        start_i;
    logic        abort_i;
    logic        err_clr_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [3:0]  cmd_cnt_o;
    logic        core_req_i;
    logic [6:0]  core_funct7_i;
    logic [31:0] core_rs1_i;
    logic [31:0] core_rs2_i;
    logic        core_ack_o;
    logic        core_error_o;
    logic [31:0] core_rd_o;
    logic        fgpio_req_o;
    logic [6:0]  fgpio_funct7_o;
    logic [31:0] fgpio_rs1_val_o;
    logic [31:0] fgpio_rs2_val_o;
    logic        fgpio_ack_i;
    logic        fgpio_error_i;
    logic [31:0] fgpio_rd_val_i;
    logic        smp_valid_o;
    logic [31:0] smp_data_o;

    int n_chk = 0;
    int n_pass = 0;

    fgpio_seq #(.DEPTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_delay_i(cmd_delay_i), .cmd_arg0_i(cmd_arg0_i), .cmd_arg1_i(cmd_arg1_i),
        .start_i(start_i), .abort_i(abort_i), .err_clr_i(err_clr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cmd_cnt_o(cmd_cnt_o),
        .core_req_i(core_req_i), .core_funct7_i(core_funct7_i),
        .core_rs1_i(core_rs1_i), .core_rs2_i(core_rs2_i),
        .core_ack_o(core_ack_o), .core_error_o(core_error_o), .core_rd_o(core_rd_o),
        .fgpio_req_o(fgpio_req_o), .fgpio_funct7_o(fgpio_funct7_o),
        .fgpio_rs1_val_o(fgpio_rs1_val_o), .fgpio_rs2_val_o(fgpio_rs2_val_o),
        .fgpio_ack_i(fgpio_ack_i), .fgpio_error_i(fgpio_error_i),
        .fgpio_rd_val_i(fgpio_rd_val_i),
        .smp_valid_o(smp_valid_o), .smp_data_o(smp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] d,
                        input logic [31:0] a0, input logic [31:0] a1);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_delay_i = d;
        cmd_arg0_i  = a0;
        cmd_arg1_i  = a1;
        cyc();
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        logic bad;
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_delay_i = 16'd0;
        cmd_arg0_i = '0; cmd_arg1_i = '0; start_i = 1'b0; abort_i = 1'b0; err_clr_i = 1'b0;
        core_req_i = 1'b1; core_funct7_i = 7'h7F; core_rs1_i = 32'h1111; core_rs2_i = 32'h2222;
        fgpio_ack_i = 1'b1; fgpio_error_i = 1'b0; fgpio_rd_val_i = 32'hC0DE_0000;

        // Reset values and pass-through while in reset.
        #3;
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_smp_valid", smp_valid_o, 0);
        chk("rst_smp_data", smp_data_o, 0);
        chk("rst_cnt", cmd_cnt_o, 0);
        chk("rst_pt_req", fgpio_req_o, 1);
        chk("rst_pt_f7", fgpio_funct7_o, 7'h7F);
        chk("rst_pt_ack", core_ack_o, 1);
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc();

        // Start on empty queue is ignored.
        start_i = 1'b1; cyc(); start_i = 1'b0; #1;
        chk("empty_start_busy", busy_o, 0);

        // WR d=3 then RD_ALL d=0, core requesting throughout: issues at T+5, T+7.
        push(2'd2, 16'd3, 32'hA5, 32'h5A);
        push(2'd0, 16'd0, 32'h10, 32'h0);
        #1;
        chk("s1_cnt", cmd_cnt_o, 2);
        start_i = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            start_i = 1'b0;
            fgpio_rd_val_i = 32'hC0DE_0000 | k;
            #1;
            chk("s1_req", fgpio_req_o, 1);
            chk("s1_f7", fgpio_funct7_o, (k == 5) ? 7'h40 : (k == 7) ? 7'h00 : 7'h7F);
            chk("s1_rs1", fgpio_rs1_val_o, (k == 5) ? 32'hA5 : (k == 7) ? 32'h10 : 32'h1111);
            chk("s1_core_ack", core_ack_o, (k == 5 || k == 7) ? 0 : 1);
            chk("s1_core_rd", core_rd_o, (k == 5 || k == 7) ? 32'h0 : (32'hC0DE_0000 | k));
            chk("s1_smp_valid", smp_valid_o, (k == 8) ? 1 : 0);
            chk("s1_done", done_o, (k == 8) ? 1 : 0);
            chk("s1_busy", busy_o, (k <= 8) ? 1 : 0);
            if (k == 8) chk("s1_smp_data", smp_data_o, 32'hC0DE_0007);
        end
        chk("s1_cnt_end", cmd_cnt_o, 0);

        // Overflow: ninth push dropped.
        core_req_i = 1'b0;
        for (int i = 0; i < 8; i++) push(2'd2, 16'd0, i, 0);
        #1;
        chk("ovf_cnt8", cmd_cnt_o, 8);
        chk("ovf_ready", cmd_ready_o, 0);
        push(2'd2, 16'd0, 32'h99, 0);
        #1;
        chk("ovf_cnt_still8", cmd_cnt_o, 8);
        abort_i = 1'b1; cyc(); abort_i = 1'b0; #1;
        chk("flush_cnt", cmd_cnt_o, 0);
        chk("flush_ready", cmd_ready_o, 1);

        // Abort exactly when the counter hits zero (T+4).
        push(2'd2, 16'd2, 32'h1, 0);
        push(2'd2, 16'd5, 32'h2, 0);
        start_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            start_i = 1'b0;
            abort_i = (k == 4);
            #1;
            chk("ab_req", fgpio_req_o, 0);
            chk("ab_done", done_o, 0);
            if (k == 3) chk("ab_busy_wait", busy_o, 1);
            if (k >= 5) chk("ab_cnt", cmd_cnt_o, 0);
            if (k >= 5) chk("ab_busy", busy_o, 0);
        end
        abort_i = 1'b0;

        // Error on first issue: sticky, sequence completes, then cleared.
        fgpio_rd_val_i = 32'h0000_BEEF;
        push(2'd1, 16'd1, 32'h7, 32'h0);
        push(2'd3, 16'd0, 32'h8, 32'h0);
        start_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            start_i = 1'b0;
            fgpio_error_i = (k == 3);
            #1;
            chk("er_req", fgpio_req_o, (k == 3 || k == 5) ? 1 : 0);
            if (k == 3) chk("er_f7_rdbit", fgpio_funct7_o, 7'h01);
            if (k == 5) chk("er_f7_wrand", fgpio_funct7_o, 7'h41);
            chk("er_err", err_o, (k >= 4) ? 1 : 0);
            chk("er_smp_valid", smp_valid_o, (k == 4) ? 1 : 0);
            chk("er_done", done_o, (k == 6) ? 1 : 0);
        end
        chk("er_smp_data", smp_data_o, 32'h0000_BEEF);
        fgpio_error_i = 1'b0;
        err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0; #1;
        chk("er_clr", err_o, 0);

        // Reset during WAIT with four queued commands.
        for (int i = 0; i < 4; i++) push(2'd2, 16'd10, i, 0);
        start_i = 1'b1;
        cyc(); start_i = 1'b0;
        cyc(); cyc(); cyc();
        rst_ni = 1'b0;
        #1;
        chk("mr_busy", busy_o, 0);
        chk("mr_cnt", cmd_cnt_o, 0);
        chk("mr_ready", cmd_ready_o, 1);
        chk("mr_err", err_o, 0);
        chk("mr_smp_data", smp_data_o, 0);
        cyc(); cyc();
        rst_ni = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (fgpio_req_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
        end
        chk("mr_no_issue", bad, 0);
        start_i = 1'b1; cyc(); start_i = 1'b0; #1;
        chk("mr_start_ignored", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
